// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, instruction field
// positions, reset PC default and the JR funct code also used by the decoder.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int TARGET_MSB = 25;
  localparam int IMM_MSB    = 15;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Branch immediates count words, so sign-extend and scale by four.
  function automatic logic [31:0] branchOffset(input logic [31:0] instrWord);
    return {{14{instrWord[IMM_MSB]}}, instrWord[IMM_MSB:0], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection: register jump beats absolute jump beats taken branch,
// everything else falls through to sequential pc+4.
module next_pc_sel
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        branch,
  input  logic        bne,
  input  logic        alu_zero,
  output logic [31:0] next_pc,
  output logic        misalign_hit
);

  logic branchTaken;
  logic unusedOpcode;

  assign branchTaken  = (branch & alu_zero) | (bne & ~alu_zero);
  assign misalign_hit = jumpReg & (jr_target[1:0] != 2'b00);
  assign unusedOpcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  // Priority mux; the low two bits of a register target are forced to zero.
  always_comb begin
    next_pc = pc_plus4;
    if (jumpReg) begin
      next_pc = {jr_target[31:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], instr[TARGET_MSB:0], 2'b00};
    end else if (branchTaken) begin
      next_pc = pc_plus4 + branchOffset(instr);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch handshake: RESET -> FETCH -> EXEC loop,
// one instruction per EXEC window, with sticky misalign and fetch-timeout flags.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DEFAULT_RESET_PC,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        jump,
  input  logic        jumpReg,
  input  logic        branch,
  input  logic        bne,
  input  logic        alu_zero,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        misalign,
  output logic        imem_err
);

  localparam int unsigned   TW             = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LIMIT  = TW'(FETCH_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST   = TW'(FETCH_TIMEOUT - 1);

  fetch_state_e  state_q;
  logic [31:0]   pc_q;
  logic [31:0]   instr_q;
  logic [31:0]   retired_q;
  logic [TW-1:0] timeoutCnt_q;
  logic          imemReq_q;
  logic          instrValid_q;
  logic          misalign_q;
  logic          imemErr_q;

  logic [31:0]   pcPlus4;
  logic [31:0]   nextPc_d;
  logic          misalignHit;

  assign pcPlus4 = pc_q + 32'd4;

  next_pc_sel uNextPcSel (
    .pc_plus4     (pcPlus4),
    .instr        (instr_q),
    .jr_target    (jr_target),
    .jump         (jump),
    .jumpReg      (jumpReg),
    .branch       (branch),
    .bne          (bne),
    .alu_zero     (alu_zero),
    .next_pc      (nextPc_d),
    .misalign_hit (misalignHit)
  );

  // Fetch/execute sequencer; request and valid are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESET;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retired_q    <= '0;
      timeoutCnt_q <= '0;
      imemReq_q    <= 1'b0;
      instrValid_q <= 1'b0;
      misalign_q   <= 1'b0;
      imemErr_q    <= 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          state_q      <= FETCH;
          imemReq_q    <= 1'b1;
          timeoutCnt_q <= '0;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q      <= imem_rdata;
            state_q      <= EXEC;
            imemReq_q    <= 1'b0;
            instrValid_q <= 1'b1;
            timeoutCnt_q <= '0;
          end else begin
            if (timeoutCnt_q != TIMEOUT_LIMIT) begin
              timeoutCnt_q <= timeoutCnt_q + TW'(1);
            end
            if (timeoutCnt_q >= TIMEOUT_LAST) begin
              imemErr_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q         <= nextPc_d;
            retired_q    <= retired_q + 32'd1;
            state_q      <= FETCH;
            imemReq_q    <= 1'b1;
            instrValid_q <= 1'b0;
            timeoutCnt_q <= '0;
            if (misalignHit) begin
              misalign_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= RESET;
          imemReq_q    <= 1'b0;
          instrValid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imemReq_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instrValid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pcPlus4;
  assign retired     = retired_q;
  assign misalign    = misalign_q;
  assign imem_err    = imemErr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each instruction pushes its expected next
// fetch address into a queue that a negedge monitor drains on every new request.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // {jumpReg, jump, branch, bne, alu_zero}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_JR    = 5'b10000;
  localparam logic [4:0] C_J     = 5'b01000;
  localparam logic [4:0] C_JRJ   = 5'b11000;
  localparam logic [4:0] C_BEQT  = 5'b00101;
  localparam logic [4:0] C_BEQN  = 5'b00100;
  localparam logic [4:0] C_BOTH  = 5'b00110;
  localparam logic [4:0] C_BNET  = 5'b00010;

  logic        clk, rst;
  logic        imem_req, imem_ack, instr_valid, stall;
  logic        jump, jumpReg, branch, bne, alu_zero, misalign, imem_err;
  logic [31:0] imem_addr, imem_rdata, instr, jr_target, pc, pc_plus4, retired;

  int          errorCount = 0;
  int          checkCount = 0;
  logic [31:0] expAddrQ[$];
  logic [31:0] modelPc;
  logic [31:0] modelRetired;
  logic        reqPrev = 1'b0;

  pc_fetch_unit #(
    .RESET_PC      (RESET_PC),
    .FETCH_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .jump        (jump),
    .jumpReg     (jumpReg),
    .branch      (branch),
    .bne         (bne),
    .alu_zero    (alu_zero),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .retired     (retired),
    .misalign    (misalign),
    .imem_err    (imem_err)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait loop is ever broken.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Each new fetch request is matched against the oldest expected address.
  always @(negedge clk) begin
    if (!rst && imem_req && !reqPrev) begin
      if (expAddrQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL fetchAddrUnexpected: actual=%h expected=none", imem_addr);
      end else begin
        checkOutput("fetchAddr", imem_addr, expAddrQ.pop_front());
      end
    end
    reqPrev <= imem_req;
  end

  task automatic waitForReq(input string tag);
    int budget = 0;
    while (imem_req !== 1'b1 && budget < 40) begin
      @(posedge clk); #1;
      budget++;
    end
    checkOutput({tag, "_reqSeen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic clearControls();
    {jumpReg, jump, branch, bne, alu_zero} = 5'b00000;
    stall     = 1'b0;
    jr_target = 32'h0;
  endtask

  // One instruction: FETCH with noisy control inputs, ack after ackDelay
  // cycles, then EXEC with the real controls and an optional stall.
  task automatic applyStimulus(input string tag, input logic [31:0] word,
                               input int ackDelay, input logic [4:0] ctl,
                               input logic [31:0] jrTgt, input int stallCycles,
                               input logic [31:0] expNext);
    {jumpReg, jump, branch, bne, alu_zero} = 5'b11110;
    stall     = 1'b1;
    jr_target = 32'h0000_0ABF;
    waitForReq(tag);
    checkOutput({tag, "_addr"}, imem_addr, modelPc);
    repeat (ackDelay) begin
      @(posedge clk); #1;
      checkOutput({tag, "_holdReq"}, 32'(imem_req), 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    {jumpReg, jump, branch, bne, alu_zero} = ctl;
    jr_target = jrTgt;
    stall     = (stallCycles > 0);
    expAddrQ.push_back(expNext);
    checkOutput({tag, "_instr"}, instr, word);
    checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
    checkOutput({tag, "_reqLowInExec"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_pcPlus4"}, pc_plus4, modelPc + 32'd4);
    for (int i = 0; i < stallCycles; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      checkOutput({tag, "_stallPc"}, pc, modelPc);
      checkOutput({tag, "_stallInstr"}, instr, word);
      checkOutput({tag, "_stallRetired"}, retired, modelRetired);
      checkOutput({tag, "_stallReq"}, 32'(imem_req), 32'd0);
      checkOutput({tag, "_stallValid"}, 32'(instr_valid), 32'd1);
    end
    imem_ack = 1'b0;
    stall    = 1'b0;
    @(posedge clk); #1;
    clearControls();
    modelPc      = expNext;
    modelRetired = modelRetired + 32'd1;
    checkOutput({tag, "_validDone"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_pc"}, pc, modelPc);
    checkOutput({tag, "_retired"}, retired, modelRetired);
  endtask

  // Directed sequence covering sequential flow, branches, jumps, stall,
  // wrap-around, fetch timeout and asynchronous reset in FETCH and EXEC.
  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    clearControls();
    modelPc      = RESET_PC;
    modelRetired = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReq", 32'(imem_req), 32'd0);
    checkOutput("rstValid", 32'(instr_valid), 32'd0);
    checkOutput("rstPc", pc, RESET_PC);
    checkOutput("rstInstr", instr, 32'h0);
    checkOutput("rstRetired", retired, 32'h0);
    checkOutput("rstMisalign", 32'(misalign), 32'd0);
    checkOutput("rstErr", 32'(imem_err), 32'd0);

    @(posedge clk); #1;
    expAddrQ.push_back(RESET_PC);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("noReqInResetState", 32'(imem_req), 32'd0);

    applyStimulus("seq0", 32'h2008_0001, 2, C_NONE, 32'h7, 0, 32'h0000_0004);
    applyStimulus("seq1", 32'h0109_5020, 2, C_NONE, 32'h7, 0, 32'h0000_0008);
    applyStimulus("seq2", 32'h0109_5022, 2, C_NONE, 32'h7, 0, 32'h0000_000C);
    checkOutput("retiredAfterThree", retired, 32'd3);
    applyStimulus("seq3", 32'h0000_0000, 0, C_NONE, 32'h0, 0, 32'h0000_0010);
    applyStimulus("beqTaken", 32'h1022_FFFC, 0, C_BEQT, 32'h0, 0, 32'h0000_0004);
    applyStimulus("seq4", 32'h0000_0000, 0, C_NONE, 32'h0, 0, 32'h0000_0008);
    applyStimulus("seq5", 32'h0000_0000, 0, C_NONE, 32'h0, 0, 32'h0000_000C);
    applyStimulus("seq6", 32'h0000_0000, 0, C_NONE, 32'h0, 0, 32'h0000_0010);
    applyStimulus("beqNotTaken", 32'h1022_FFFC, 0, C_BEQN, 32'h0, 0, 32'h0000_0014);
    applyStimulus("beqBneBoth", 32'h1022_0001, 0, C_BOTH, 32'h0, 0, 32'h0000_001C);
    applyStimulus("seq7", 32'h0000_0000, 1, C_NONE, 32'h0, 0, 32'h0000_0020);
    applyStimulus("bneTaken", 32'h1422_0003, 0, C_BNET, 32'h0, 0, 32'h0000_0030);
    applyStimulus("jrAligned", 32'h03E0_0008, 0, C_JR, 32'h1000_0000, 0, 32'h1000_0000);
    checkOutput("misalignClearAfterAlignedJr", 32'(misalign), 32'd0);
    applyStimulus("jump", 32'h0800_0040, 0, C_J, 32'h0, 0, 32'h1000_0100);
    applyStimulus("jrMisaligned", 32'h03E0_0008, 0, C_JR, 32'h0000_0203, 0, 32'h0000_0200);
    checkOutput("misalignSet", 32'(misalign), 32'd1);
    applyStimulus("jrBeatsJump", 32'h0800_0001, 0, C_JRJ, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC);
    applyStimulus("stallWrap", 32'h0000_0000, 0, C_NONE, 32'h0, 5, 32'h0000_0000);
    checkOutput("misalignSticky", 32'(misalign), 32'd1);
    checkOutput("retiredTotal", retired, 32'd17);

    // No ack: flag must rise on exactly the sixteenth FETCH cycle.
    repeat (15) begin
      @(posedge clk); #1;
    end
    checkOutput("errBeforeTimeout", 32'(imem_err), 32'd0);
    @(posedge clk); #1;
    checkOutput("errAtTimeout", 32'(imem_err), 32'd1);
    checkOutput("reqHeldAfterTimeout", 32'(imem_req), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("errSticky", 32'(imem_err), 32'd1);
    checkOutput("addrHeldAfterTimeout", imem_addr, 32'h0000_0000);

    // Reset in the middle of a FETCH cycle.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midFetchRstReq", 32'(imem_req), 32'd0);
    checkOutput("midFetchRstPc", pc, RESET_PC);
    checkOutput("midFetchRstErr", 32'(imem_err), 32'd0);
    checkOutput("midFetchRstMisalign", 32'(misalign), 32'd0);
    checkOutput("midFetchRstRetired", retired, 32'h0);
    modelPc      = RESET_PC;
    modelRetired = 32'h0;
    @(posedge clk); #1;
    expAddrQ.push_back(RESET_PC);
    rst = 1'b0;
    applyStimulus("afterReset", 32'h2008_0001, 1, C_NONE, 32'h7, 0, 32'h0000_0004);

    // Reset in the middle of an EXEC cycle.
    waitForReq("execReset");
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checkOutput("execValidBeforeRst", 32'(instr_valid), 32'd1);
    checkOutput("execPcBeforeRst", pc, 32'h0000_0004);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("execRstValid", 32'(instr_valid), 32'd0);
    checkOutput("execRstInstr", instr, 32'h0);
    checkOutput("execRstPc", pc, RESET_PC);
    @(negedge clk);
    checkOutput("scoreboardEmpty", 32'(expAddrQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the instruction-fetch handshake to instruction memory.
- Presents each fetched word to the control decoder and datapath for one execute window.
- Consumes the decoder's jump, jumpReg, branch and bne outputs, plus the ALU zero flag, to select the next PC.
- Sits upstream of the control unit and closes the fetch/decode/PC-update loop of the single-issue core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, cycles in FETCH without imem_ack before imem_err is raised.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address (equals pc).
- imem_ack  in  1  memory response valid.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1 in FETCH.
- instr  out  32  latched instruction; opcode=[31:26], funct=[5:0] go to the decoder.
- instr_valid  out  1  high for the whole EXEC state.
- stall  in  1  datapath hold request; sampled only in EXEC.
- jump, jumpReg, branch, bne  in  1 each  from the control unit.
- alu_zero  in  1  ALU zero flag for branch resolution.
- jr_target  in  32  rs register value, used when jumpReg=1.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, the JAL link value.
- retired  out  32  count of completed instructions.
- misalign  out  1  sticky: a jr_target with bits[1:0]≠0 was taken.
- imem_err  out  1  sticky: fetch timeout occurred.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-fetch):
  - state=RESET, pc=RESET_PC, instr=0, retired=0.
  - imem_req=0, instr_valid=0, misalign=0, imem_err=0.
- States:
  - RESET → FETCH after one cycle. No request is issued in RESET.
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_ack: instr<=imem_rdata, go to EXEC next cycle.
    - A timeout counter counts cycles without ack. On reaching FETCH_TIMEOUT, set imem_err=1 and stay in FETCH, still requesting.
    - The timeout counter clears on ack and on entry to FETCH.
  - EXEC: instr_valid=1, imem_req=0.
    - If stall=1: hold everything.
    - Else: pc<=next_pc, retired<=retired+1, go to FETCH.
- next_pc priority (highest first):
  - jumpReg: {jr_target[31:2],2'b00}. misalign is set if jr_target[1:0]≠0.
  - jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - taken branch: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), where taken = (branch & alu_zero) | (bne & ~alu_zero).
  - otherwise: pc_plus4.
- Arithmetic:
  - All adds are modulo 2^32. pc=32'hFFFF_FFFC advances to 0 with no flag.
  - retired wraps from FFFF_FFFF to 0.
- Boundary conditions:
  - imem_ack outside FETCH is ignored.
  - Control inputs are ignored outside EXEC.
  - Both branch and bne high: OR rule above applies, no error.
  - Minimum latency per instruction: 2 cycles (FETCH with same-cycle ack, then EXEC).
  - Reset arriving during EXEC drops instr_valid asynchronously.

Decomposition:
- Shared package holds:
  - state encoding: RESET, FETCH, EXEC.
  - instruction field bit positions.
  - the RESET_PC default.
  - the JR funct constant 6'b001000, shared with the control unit.
- Sub-module next_pc_sel: purely combinational priority mux and adders. Inputs: pc_plus4, instr, jr_target, control bits, alu_zero. Outputs: next_pc, misalign_hit.

Test Plan:
- Reset release, memory acks after 2 cycles, 3 sequential non-branch words → imem_addr 0,4,8, retired=3, each instr_valid window one cycle.
- beq at pc=0x10, imm=16'hFFFC, branch=1, alu_zero=1 → next fetch at 0x04. Same with alu_zero=0 → 0x14.
- bne=1, alu_zero=0 at pc=0x20, imm=3 → 0x30. jump at pc=0x1000_0000 with target 26'h40 → 0x1000_0100.
- jumpReg with jr_target=0x203 → fetch 0x200, misalign=1 and stays set until reset. jumpReg+jump simultaneously → jr wins.
- stall held 5 cycles in EXEC → pc, instr and retired frozen, no imem_req. pc=FFFF_FFFC sequential → next fetch at 0.
- No ack for 16 cycles → imem_err=1, req held. Assert rst mid-FETCH → imem_req drops the same cycle, pc=RESET_PC.
